// File: rtl/rand_delay_sched.sv
// Random-delay scheduler: latches MIN_MS plus a random span on start, counts it
// down on 1 ms ticks, then pulses fire (or aborted if cancelled first).
module rand_delay_sched #(
  parameter int MIN_MS    = 1000,
  parameter int SPAN_LOG2 = 12,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      rnd_in,
  input  logic             start,
  input  logic             abort,
  input  logic             tick_1ms,
  output logic             busy,
  output logic             fire,
  output logic             aborted,
  output logic [CNT_W-1:0] delay_ms,
  output logic [CNT_W-1:0] remain_ms
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_MS);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_t           state_q, state_d;
  logic             busy_d, fire_d, aborted_d;
  logic [CNT_W-1:0] delay_d, remain_d;
  logic [CNT_W-1:0] new_delay;
  logic             rnd_unused;

  // Only the low SPAN_LOG2 bits of the LFSR word shape the delay.
  assign new_delay  = MIN_C + CNT_W'(rnd_in[SPAN_LOG2-1:0]);
  assign rnd_unused = ^rnd_in;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      busy      <= 1'b0;
      fire      <= 1'b0;
      aborted   <= 1'b0;
      delay_ms  <= '0;
      remain_ms <= '0;
    end else begin
      state_q   <= state_d;
      busy      <= busy_d;
      fire      <= fire_d;
      aborted   <= aborted_d;
      delay_ms  <= delay_d;
      remain_ms <= remain_d;
    end
  end

  // Abort outranks the tick in ARMED so a cancel always wins, even on the last ms.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy;
    fire_d    = 1'b0;
    aborted_d = 1'b0;
    delay_d   = delay_ms;
    remain_d  = remain_ms;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          delay_d  = new_delay;
          remain_d = new_delay;
          busy_d   = 1'b1;
          state_d  = ARMED;
        end
      end
      ARMED: begin
        if (abort) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          aborted_d = 1'b1;
          remain_d  = '0;
        end else if (tick_1ms) begin
          if (remain_ms > ONE_C) begin
            remain_d = remain_ms - ONE_C;
          end else begin
            remain_d = '0;
            fire_d   = 1'b1;
            state_d  = FIRE;
          end
        end
      end
      FIRE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_rand_delay_sched.sv
// Bench for rand_delay_sched: a small-parameter instance for round behaviour and a
// default-parameter instance for the long 1291 ms delay.
module tb_rand_delay_sched;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] rnd_in = '0;
  logic        start = 1'b0, abort = 1'b0, tick_1ms = 1'b0;
  logic        busy, fire, aborted;
  logic [15:0] delay_ms, remain_ms;

  logic        start_d = 1'b0, abort_d = 1'b0, tick_d = 1'b0;
  logic        busy_d, fire_d, aborted_d;
  logic [15:0] delay_ms_d, remain_ms_d;

  int errors = 0;
  int checks = 0;
  int round_ticks = 0;
  int fire_d_count = 0;

  typedef struct {
    logic        is_fire;
    logic [15:0] delay;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  rand_delay_sched #(.MIN_MS(3), .SPAN_LOG2(2), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .rnd_in(rnd_in), .start(start), .abort(abort),
    .tick_1ms(tick_1ms), .busy(busy), .fire(fire), .aborted(aborted),
    .delay_ms(delay_ms), .remain_ms(remain_ms)
  );

  rand_delay_sched dut_def (
    .clk(clk), .reset_n(reset_n), .rnd_in(rnd_in), .start(start_d), .abort(abort_d),
    .tick_1ms(tick_d), .busy(busy_d), .fire(fire_d), .aborted(aborted_d),
    .delay_ms(delay_ms_d), .remain_ms(remain_ms_d)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic t);
    start = s;
    abort = a;
    tick_1ms = t;
    if (t) round_ticks++;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    tick_1ms = 1'b0;
  endtask

  task automatic pushExpect(input logic is_fire, input logic [15:0] dly);
    exp_t e;
    e.is_fire = is_fire;
    e.delay   = dly;
    sb_q.push_back(e);
  endtask

  task automatic gapTicks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
  endtask

  // Each fire/aborted pulse must match the oldest expected round outcome.
  always @(negedge clk) begin
    if (reset_n && (fire || aborted)) begin
      if (sb_q.size() == 0) begin
        checkOutput("sb_unexpected_event", 32'(fire) + 32'(aborted), 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        checkOutput("sb_fire", 32'(fire), 32'(e.is_fire));
        checkOutput("sb_aborted", 32'(aborted), 32'(!e.is_fire));
        checkOutput("sb_delay", 32'(delay_ms), 32'(e.delay));
        if (e.is_fire) checkOutput("sb_ticks", round_ticks, 32'(e.delay));
      end
    end
    if (reset_n && fire_d) fire_d_count++;
  end

  initial begin
    #12;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_fire", 32'(fire), 0);
    checkOutput("rst_aborted", 32'(aborted), 0);
    checkOutput("rst_delay", 32'(delay_ms), 0);
    checkOutput("rst_remain", 32'(remain_ms), 0);
    checkOutput("rst_def_delay", 32'(delay_ms_d), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Default parameters: 1000 + 0x123 = 1291 ms
    rnd_in = 32'h0000_0123;
    start_d = 1'b1;
    @(posedge clk); #1;
    start_d = 1'b0;
    checkOutput("def_delay", 32'(delay_ms_d), 1291);
    checkOutput("def_busy", 32'(busy_d), 1);
    tick_d = 1'b1;
    for (int i = 0; i < 1290; i++) begin
      @(posedge clk); #1;
    end
    tick_d = 1'b0;
    checkOutput("def_remain_last", 32'(remain_ms_d), 1);
    checkOutput("def_no_early_fire", 32'(fire_d_count), 0);
    tick_d = 1'b1;
    @(posedge clk); #1;
    tick_d = 1'b0;
    checkOutput("def_fire", 32'(fire_d), 1);
    @(posedge clk); #1;
    checkOutput("def_fire_done", 32'(fire_d), 0);
    checkOutput("def_busy_done", 32'(busy_d), 0);

    // Sampling and fire timing: 3 + (0xF6 & 3) = 5
    rnd_in = 32'hFFFF_FFF6;
    applyStimulus(1'b1, 1'b0, 1'b0);
    round_ticks = 0;
    pushExpect(1'b1, 16'd5);
    checkOutput("t1_busy", 32'(busy), 1);
    checkOutput("t1_delay", 32'(delay_ms), 5);
    checkOutput("t1_remain", 32'(remain_ms), 5);
    gapTicks(4);
    checkOutput("t1_remain1", 32'(remain_ms), 1);
    checkOutput("t1_busy_armed", 32'(busy), 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t1_fire", 32'(fire), 1);
    checkOutput("t1_busy_fire", 32'(busy), 1);
    checkOutput("t1_remain0", 32'(remain_ms), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t1_fire_clr", 32'(fire), 0);
    checkOutput("t1_busy_clr", 32'(busy), 0);

    // Abort mid-count
    applyStimulus(1'b1, 1'b0, 1'b0);
    round_ticks = 0;
    pushExpect(1'b0, 16'd5);
    gapTicks(2);
    checkOutput("t3_remain", 32'(remain_ms), 3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t3_aborted", 32'(aborted), 1);
    checkOutput("t3_busy", 32'(busy), 0);
    checkOutput("t3_delay_held", 32'(delay_ms), 5);
    checkOutput("t3_remain0", 32'(remain_ms), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t3_aborted_clr", 32'(aborted), 0);

    // Abort coincident with the final tick
    applyStimulus(1'b1, 1'b0, 1'b0);
    round_ticks = 0;
    pushExpect(1'b0, 16'd5);
    gapTicks(4);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("t4_aborted", 32'(aborted), 1);
    checkOutput("t4_no_fire", 32'(fire), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Abort during FIRE is ignored: delay 3 + 1 = 4
    rnd_in = 32'h0000_0001;
    applyStimulus(1'b1, 1'b0, 1'b0);
    round_ticks = 0;
    pushExpect(1'b1, 16'd4);
    gapTicks(3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t4b_fire", 32'(fire), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t4b_no_abort", 32'(aborted), 0);
    checkOutput("t4b_busy", 32'(busy), 0);

    // Tick with start ignored; start while ARMED ignored; abort in IDLE ignored
    rnd_in = 32'h0000_0002;
    applyStimulus(1'b1, 1'b0, 1'b1);
    round_ticks = 0;
    pushExpect(1'b1, 16'd5);
    checkOutput("t5_remain_full", 32'(remain_ms), 5);
    rnd_in = 32'h0000_0003;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("t5_delay_kept", 32'(delay_ms), 5);
    gapTicks(4);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t5_fire", 32'(fire), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t5_idle_abort", 32'(aborted), 0);
    checkOutput("t5_idle_busy", 32'(busy), 0);

    // start held high: one IDLE cycle between fire and the next round
    rnd_in = 32'h0000_0000;
    applyStimulus(1'b1, 1'b0, 1'b0);
    round_ticks = 0;
    pushExpect(1'b1, 16'd3);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("bb_fire", 32'(fire), 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("bb_idle_gap", 32'(busy), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    round_ticks = 0;
    pushExpect(1'b0, 16'd3);
    checkOutput("bb_rearm", 32'(busy), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("bb_aborted", 32'(aborted), 1);

    // Asynchronous reset while ARMED with 3 ms left
    rnd_in = 32'h0000_0002;
    applyStimulus(1'b1, 1'b0, 1'b0);
    gapTicks(2);
    checkOutput("t6_remain", 32'(remain_ms), 3);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_busy", 32'(busy), 0);
    checkOutput("t6_delay", 32'(delay_ms), 0);
    checkOutput("t6_remain0", 32'(remain_ms), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("t6_no_restart", 32'(busy), 0);
    checkOutput("t6_no_fire", 32'(fire), 0);

    checkOutput("sb_empty", sb_q.size(), 0);
    checkOutput("def_fire_once", fire_d_count, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
